// File: rtl/mmio_responder.sv
// mmio_responder: memory-mapped I/O target on the core's dmem port.
// Serves OUT, a synchronized IN port, MTIME/MTIMECMP with a compare flag, and STATUS.
// Ports:
//   clk          rising-edge clock
//   rst_n_i      synchronous active-low reset
//   dmem_addr_i  byte address;  dmem_data_i  store data (sub-word in low bits)
//   dmem_rd_en_i / dmem_wr_en_i  load / store request
//   dmem_size_i  0 byte, 1 half, 2 word, 3 illegal
//   dmem_sign_i  1 zero-extend, 0 sign-extend on sub-word loads
//   dmem_data_o  load data one cycle after the request, zero when not owner
//   io_in_i      asynchronous input pins;  io_out_o  OUT register
//   irq_o        timer pending flag;  err_o  one-cycle pulse after a faulting access
module mmio_responder #(
    parameter logic [31:0] BASE_ADDR      = 32'h1100_0000,
    parameter int          IN_SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n_i,
    input  logic [31:0] dmem_addr_i,
    input  logic [31:0] dmem_data_i,
    input  logic        dmem_rd_en_i,
    input  logic        dmem_wr_en_i,
    input  logic [1:0]  dmem_size_i,
    input  logic        dmem_sign_i,
    output logic [31:0] dmem_data_o,
    input  logic [31:0] io_in_i,
    output logic [31:0] io_out_o,
    output logic        irq_o,
    output logic        err_o
);
    logic [31:0] out_q, mtime_q, mtimecmp_q;
    logic        pending_q, err_q;
    logic [31:0] sync_q [IN_SYNC_STAGES];
    logic [5:0]  idx;
    logic [4:0]  sh;
    logic        sel, mapped, misaligned, fault, rd_ok, wr_ok, match;
    logic [31:0] cur, shifted, loaded, mask, wdata, merged;
    logic [1:0]  clr;

    always_comb begin
        idx        = dmem_addr_i[7:2];
        sh         = {dmem_addr_i[1:0], 3'b000};
        sel        = (dmem_addr_i[31:8] == BASE_ADDR[31:8]) && (dmem_rd_en_i || dmem_wr_en_i);
        mapped     = idx <= 6'd4;
        misaligned = (dmem_size_i == 2'd3)
                  || (dmem_size_i == 2'd1 && dmem_addr_i[0])
                  || (dmem_size_i == 2'd2 && dmem_addr_i[1:0] != 2'd0);
        fault      = sel && (misaligned || (dmem_rd_en_i && dmem_wr_en_i) || !mapped);
        rd_ok      = sel && dmem_rd_en_i && !fault;
        wr_ok      = sel && dmem_wr_en_i && !fault;
        match      = mtime_q == mtimecmp_q;
        cur        = idx == 6'd0 ? out_q :
                     idx == 6'd1 ? sync_q[IN_SYNC_STAGES-1] :
                     idx == 6'd2 ? mtime_q :
                     idx == 6'd3 ? mtimecmp_q :
                     idx == 6'd4 ? {30'd0, err_q, pending_q} : 32'd0;
        // lane is right-justified first, then extended from the lane's top bit
        shifted    = cur >> sh;
        loaded     = dmem_size_i == 2'd0 ? {{24{~dmem_sign_i & shifted[7]}}, shifted[7:0]} :
                     dmem_size_i == 2'd1 ? {{16{~dmem_sign_i & shifted[15]}}, shifted[15:0]} :
                     shifted;
        mask       = (dmem_size_i == 2'd0 ? 32'h0000_00FF :
                      dmem_size_i == 2'd1 ? 32'h0000_FFFF : 32'hFFFF_FFFF) << sh;
        wdata      = (dmem_data_i << sh) & mask;
        merged     = (cur & ~mask) | wdata;
        // STATUS is write-1-to-clear over the written lanes only
        clr        = (wr_ok && idx == 6'd4) ? wdata[1:0] : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (!rst_n_i) begin
            out_q       <= '0;
            mtime_q     <= '0;
            mtimecmp_q  <= '1;
            pending_q   <= 1'b0;
            err_q       <= 1'b0;
            dmem_data_o <= '0;
            err_o       <= 1'b0;
            for (int i = 0; i < IN_SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= io_in_i;
            for (int i = 1; i < IN_SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            dmem_data_o <= rd_ok ? loaded : 32'd0;
            err_o       <= fault;
            if (wr_ok && idx == 6'd0) out_q <= merged;
            mtime_q     <= (wr_ok && idx == 6'd2) ? merged : mtime_q + 32'd1;
            if (wr_ok && idx == 6'd3) mtimecmp_q <= merged;
            // new sets win over same-cycle clears
            pending_q   <= match || (pending_q && !clr[0]);
            err_q       <= fault || (err_q && !clr[1]);
        end
    end

    assign io_out_o = out_q;
    assign irq_o    = pending_q;
endmodule

// File: tb/tb_mmio_responder.sv
// tb_mmio_responder: directed stimulus, byte-level reference model, per-cycle compare.
module tb_mmio_responder;
    localparam logic [31:0] BASE = 32'h1100_0000;
    localparam int NS = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = '0, wdat = '0, io_in = '0;
    logic        rd = 1'b0, wr = 1'b0, sign = 1'b0;
    logic [1:0]  size = '0;
    logic [31:0] dmem_data, io_out;
    logic        irq, err;

    int checks = 0;
    int passes = 0;

    mmio_responder #(.BASE_ADDR(BASE), .IN_SYNC_STAGES(NS)) dut (
        .clk(clk), .rst_n_i(rst_n), .dmem_addr_i(addr), .dmem_data_i(wdat),
        .dmem_rd_en_i(rd), .dmem_wr_en_i(wr), .dmem_size_i(size), .dmem_sign_i(sign),
        .dmem_data_o(dmem_data), .io_in_i(io_in), .io_out_o(io_out),
        .irq_o(irq), .err_o(err)
    );

    always #5 clk = ~clk;

    // reference model state: what the outputs must be after the latest edge
    logic [31:0] m_out, m_mtime, m_cmp, m_data;
    logic        m_pend, m_errs, m_erro;
    logic [31:0] m_sync[$];
    bit          m_valid = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_step();
        logic [31:0] v, nv, wb, val, in_now;
        logic [7:0]  off;
        int          lane, nb;
        bit          sel, flt, mapped, match, wr_ok;
        if (!rst_n) begin
            m_out = 0; m_mtime = 0; m_cmp = 32'hFFFF_FFFF; m_pend = 0; m_errs = 0;
            m_data = 0; m_erro = 0; m_sync = {};
            for (int i = 0; i < NS; i++) m_sync.push_back(32'd0);
            m_valid = 1;
            return;
        end
        if (!m_valid) return;
        in_now = m_sync[NS-1];
        m_sync.push_front(io_in);
        void'(m_sync.pop_back());
        off    = addr[7:0] & 8'hFC;
        lane   = int'(addr[1:0]);
        nb     = size == 2'd0 ? 1 : size == 2'd1 ? 2 : 4;
        sel    = addr[31:8] == BASE[31:8] && (rd || wr);
        mapped = off inside {8'h00, 8'h04, 8'h08, 8'h0C, 8'h10};
        flt    = sel && (size == 2'd3 || (size == 2'd1 && lane % 2 != 0) ||
                         (size == 2'd2 && lane != 0) || (rd && wr) || !mapped);
        case (off)
            8'h00:   v = m_out;
            8'h04:   v = in_now;
            8'h08:   v = m_mtime;
            8'h0C:   v = m_cmp;
            8'h10:   v = {30'd0, m_errs, m_pend};
            default: v = 0;
        endcase
        val = 0; nv = v; wb = 0;
        if (!flt && sel) begin
            for (int b = 0; b < nb; b++) begin
                val[8*b +: 8]        = v[8*(lane+b) +: 8];
                nv[8*(lane+b) +: 8]  = wdat[8*b +: 8];
                wb[8*(lane+b) +: 8]  = wdat[8*b +: 8];
            end
            if (!sign && nb < 4 && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8*nb));
        end
        match  = m_mtime == m_cmp;
        wr_ok  = sel && wr && !flt;
        m_data = (sel && rd && !flt) ? val : 32'd0;
        m_erro = flt;
        if (wr_ok && off == 8'h00) m_out = nv;
        m_mtime = (wr_ok && off == 8'h08) ? nv : m_mtime + 1;
        if (wr_ok && off == 8'h0C) m_cmp = nv;
        m_pend = match || (m_pend && !(wr_ok && off == 8'h10 && wb[0]));
        m_errs = flt || (m_errs && !(wr_ok && off == 8'h10 && wb[1]));
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            chk("model dmem_data_o", dmem_data, m_data);
            chk("model io_out_o", io_out, m_out);
            chk("model irq_o", {31'd0, irq}, {31'd0, m_pend});
            chk("model err_o", {31'd0, err}, {31'd0, m_erro});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic req(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, input logic sg);
        rd = r; wr = w; addr = a; wdat = d; size = sz; sign = sg;
        @(posedge clk);
        @(negedge clk);
        rd = 0; wr = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset io_out", io_out, 32'd0);
        chk("reset data", dmem_data, 32'd0);
        chk("reset irq", {31'd0, irq}, 32'd0);
        chk("reset err", {31'd0, err}, 32'd0);
        rst_n = 1;

        req(0, 1, BASE, 32'hDEAD_BEEF, 2'd2, 0);
        chk("sw out", io_out, 32'hDEAD_BEEF);
        req(1, 0, BASE, 0, 2'd2, 0);
        chk("lw out", dmem_data, 32'hDEAD_BEEF);
        idle(1);
        chk("idle data", dmem_data, 32'd0);

        req(0, 1, BASE + 3, 32'h0000_0080, 2'd0, 0);
        chk("sb out", io_out, 32'h80AD_BEEF);
        req(1, 0, BASE + 3, 0, 2'd0, 0);
        chk("lb", dmem_data, 32'hFFFF_FF80);
        req(1, 0, BASE + 3, 0, 2'd0, 1);
        chk("lbu", dmem_data, 32'h0000_0080);
        req(1, 0, BASE + 2, 0, 2'd1, 0);
        chk("lh", dmem_data, 32'hFFFF_80AD);

        req(0, 1, BASE + 8, 32'hFFFF_FFFE, 2'd2, 0);
        req(0, 1, BASE + 12, 32'h0000_0001, 2'd2, 0);
        req(1, 0, BASE + 8, 0, 2'd2, 0);
        chk("mtime pre-wrap", dmem_data, 32'hFFFF_FFFF);
        req(1, 0, BASE + 8, 0, 2'd2, 0);
        chk("mtime wrapped", dmem_data, 32'd0);
        chk("irq before match", {31'd0, irq}, 32'd0);
        idle(1);
        chk("irq on match", {31'd0, irq}, 32'd1);
        req(0, 1, BASE + 16, 32'd1, 2'd2, 0);
        chk("w1c no match", {31'd0, irq}, 32'd0);
        req(0, 1, BASE + 8, 32'd1, 2'd2, 0);
        req(0, 1, BASE + 16, 32'd1, 2'd2, 0);
        chk("w1c vs match", {31'd0, irq}, 32'd1);
        req(0, 1, BASE + 16, 32'd1, 2'd2, 0);
        chk("w1c after match", {31'd0, irq}, 32'd0);

        req(1, 0, BASE, 0, 2'd2, 0);
        req(1, 0, BASE + 2, 0, 2'd2, 0);
        chk("misaligned lw err", {31'd0, err}, 32'd1);
        chk("misaligned lw data", dmem_data, 32'd0);
        idle(1);
        chk("err one cycle", {31'd0, err}, 32'd0);
        req(0, 1, BASE + 1, 32'h0000_1234, 2'd1, 0);
        chk("misaligned sh err", {31'd0, err}, 32'd1);
        chk("misaligned sh out", io_out, 32'h80AD_BEEF);
        req(1, 0, BASE + 32'h20, 0, 2'd2, 0);
        chk("unmapped err", {31'd0, err}, 32'd1);
        req(1, 1, BASE, 32'd0, 2'd2, 0);
        chk("rd+wr err", {31'd0, err}, 32'd1);
        chk("rd+wr out", io_out, 32'h80AD_BEEF);
        req(1, 0, BASE + 16, 0, 2'd2, 0);
        chk("status sticky", dmem_data, 32'd2);
        req(0, 1, BASE + 16, 32'd2, 2'd2, 0);
        req(1, 0, BASE + 16, 0, 2'd2, 0);
        chk("status cleared", dmem_data, 32'd0);

        req(1, 0, BASE, 0, 2'd2, 0);
        req(1, 0, 32'h0000_1000, 0, 2'd2, 0);
        chk("foreign data", dmem_data, 32'd0);
        chk("foreign err", {31'd0, err}, 32'd0);

        #3 io_in = 32'hA5A5_0000;
        @(negedge clk);
        idle(1);
        req(1, 0, BASE + 4, 0, 2'd2, 0);
        chk("in sync", dmem_data, 32'hA5A5_0000);
        req(0, 1, BASE + 4, 32'h1111_1111, 2'd2, 0);
        chk("in write no err", {31'd0, err}, 32'd0);
        req(1, 0, BASE + 4, 0, 2'd2, 0);
        chk("in unchanged", dmem_data, 32'hA5A5_0000);

        req(1, 0, BASE, 0, 2'd2, 0);
        chk("pre-reset load", dmem_data, 32'h80AD_BEEF);
        rst_n = 0;
        req(0, 1, BASE, 32'h1234_5678, 2'd2, 0);
        chk("reset data", dmem_data, 32'd0);
        chk("reset out", io_out, 32'd0);
        rst_n = 1;
        req(1, 0, BASE + 8, 0, 2'd2, 0);
        chk("reset mtime", dmem_data, 32'd0);
        req(1, 0, BASE + 12, 0, 2'd2, 0);
        chk("reset mtimecmp", dmem_data, 32'hFFFF_FFFF);
        req(1, 0, BASE + 16, 0, 2'd2, 0);
        chk("reset status", dmem_data, 32'd0);
        idle(2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/mmio_responder.md
# mmio_responder

Memory-mapped I/O responder on the core's data-memory port, the target-side counterpart of the core's dmem initiator. It decodes accesses in the I/O region, serves an output register, a synchronized input port, a free-running timer with compare interrupt, and a status register. It has BRAM-equivalent one-cycle read latency. Its read data is zero whenever it did not own the previous access, so the top level ORs it with the BRAM read data.

## Interface
- BASE_ADDR, 32'h1100_0000, region base; region is BASE_ADDR..BASE_ADDR+0xFF (addr[31:8] match).
- IN_SYNC_STAGES, 2, synchronizer flops on io_in_i (min 2).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n_i  in  1  synchronous, active-low reset.
- dmem_addr_i  in  32  byte address from core.
- dmem_data_i  in  32  store data (core's dmem_data_o); sub-word data in low bits.
- dmem_rd_en_i  in  1  load request.
- dmem_wr_en_i  in  1  store request.
- dmem_size_i  in  2  0 byte, 1 half, 2 word; 3 illegal.
- dmem_sign_i  in  1  1 = zero-extend (funct3[2]), 0 = sign-extend.
- dmem_data_o  out  32  load data, valid cycle after request.
- io_in_i  in  32  asynchronous input pins.
- io_out_o  out  32  output register.
- irq_o  out  1  timer pending flag.
- err_o  out  1  one-cycle pulse on faulting access.

## Operation
- sel = addr[31:8]==BASE_ADDR[31:8] & (rd_en | wr_en); no effect when sel low.
- Register map (offset = addr[7:0] & ~3):
  - 0x00 OUT: RW; drives io_out_o.
  - 0x04 IN: RO; synchronized io_in_i; writes ignored.
  - 0x08 MTIME: RW; +1 every cycle, wraps 0xFFFF_FFFF->0; a write loads the value (no increment that cycle).
  - 0x0C MTIMECMP: RW.
  - 0x10 STATUS: bit0 timer_pending, bit1 err_sticky; write-1-to-clear; other bits read 0.
  - other offsets: unmapped, so the access faults.
- Fault conditions, any of which suppresses the write, forces read data 0, pulses err_o and sets err_sticky:
  - size 3;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - rd_en & wr_en together;
  - unmapped offset.
- Sub-word stores use lane = addr[1:0]. Byte writes data[7:0] into bits lane*8+:8. Half writes data[15:0] into bits lane*8+:16. Other bits are unchanged. Partial writes to MTIME/MTIMECMP/STATUS follow the same rule.
- Sub-word loads extract the same lane, right-justify it, then sign- or zero-extend it per dmem_sign_i.
- timer_pending is set every cycle MTIME==MTIMECMP. Set beats a W1C clear in the same cycle. irq_o = timer_pending.
- err_sticky: a set from a new fault beats a W1C clear in the same cycle.

## Timing
- Reset values:
  - io_out_o=0, dmem_data_o=0, irq_o=0, err_o=0;
  - MTIME=0, MTIMECMP=0xFFFF_FFFF, STATUS=0;
  - synchronizer flops=0.
- Read latency 1 cycle: request at edge N gives dmem_data_o valid after edge N+1.
  - dmem_data_o holds that value while no new request arrives.
  - dmem_data_o returns to 0 after the first edge with a non-selected or no request. Zero output when not owner is mandatory for OR-muxing.
- Read value reflects register state before any same-cycle update (read-before-write). MTIME read returns the pre-increment value.
- Writes take effect at the edge of the request cycle. io_out_o changes on that same edge.
- err_o is registered and asserts the cycle after the faulting request for exactly one cycle.
- IN lags io_in_i by IN_SYNC_STAGES edges, plus the 1-cycle read latency.
- Reset mid-access: the pending read is discarded, dmem_data_o=0 next cycle, and no write commits.
- No back-pressure; a new request is accepted every cycle.

## Test plan
- Reset, then word-store 0xDEADBEEF to 0x1100_0000 and read it back -> io_out_o=0xDEADBEEF after the store edge; dmem_data_o=0xDEADBEEF one cycle after the load; 0 the following idle cycle.
- Byte-store 0x80 to 0x1100_0003, then lb / lbu / lh at offsets 0x03 and 0x02 -> OUT=0x80ADBEEF; lb=0xFFFFFF80, lbu=0x00000080, lh at 0x02=0xFFFF80AD.
- Write MTIME=0xFFFF_FFFE and MTIMECMP=0x0000_0001:
  - MTIME wraps to 0 two cycles later and irq_o rises when MTIME==1;
  - W1C to STATUS bit0 in the same cycle as a match -> irq_o stays 1;
  - W1C on a non-match cycle -> irq_o=0.
- Faults: word load at 0x1100_0002, half store at 0x1100_0001, load at offset 0x20, rd_en&wr_en together -> each gives an err_o 1-cycle pulse, dmem_data_o=0, no register change, STATUS bit1=1.
- Non-owned access: load at 0x0000_1000 -> dmem_data_o=0, no err_o.
- io_in_i=0xA5A5_0000 applied asynchronously; load IN after 2 edges -> returns 0xA5A5_0000.
- Assert rst_n_i=0 on the cycle after a load request -> dmem_data_o=0 and all registers at reset values.
